// File: rtl/pipe_issue_ctrl.sv
// Issue controller for a 5-stage in-order pipeline front end.
// Fetches from instruction memory at AddrIn. Each RUN cycle it either issues
// the instruction, stalls it on a RAW hazard against the three older
// in-flight writers, or, on HALT_OP, drains the pipeline for 4 cycles and
// then pulses done.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        begins a run when sampled high in IDLE
//   Instr        instruction memory read data for AddrIn
//   AddrIn       registered PC
//   Issue        combinational: IF_ID captures IssuedInstr as real
//   IssuedInstr  combinational: Instr when issuing, else 32'h0 bubble
//   Stall        combinational: RUN cycle blocked by a RAW hazard
//   busy         registered: high in RUN and DRAIN
//   done         registered: one-cycle pulse on the first IDLE cycle after DRAIN
//   StallCount   registered: hazard-stall cycles in the current/last run
module pipe_issue_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] Instr,
    output logic [31:0] AddrIn,
    output logic        Issue,
    output logic [31:0] IssuedInstr,
    output logic        Stall,
    output logic        busy,
    output logic        done,
    output logic [15:0] StallCount
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned SB_DEPTH = 3;
    localparam int unsigned SCNT_W   = 16;
    localparam int unsigned DCNT_W   = 3;

    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(3);
    localparam logic [SCNT_W-1:0] SCNT_MAX   = {SCNT_W{1'b1}};
    localparam logic [XLEN-1:0]   PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]   addr_d;
    logic [SCNT_W-1:0] scnt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              done_d;
    logic              busy_d;

    // Scoreboard: entry 0 = issued 1 cycle ago (ID), 1 = EX, 2 = MEM.
    logic [SB_DEPTH-1:0] sbv_q, sbv_d;
    logic [REG_W-1:0]    sbrd_q [SB_DEPTH];
    logic [REG_W-1:0]    sbrd_d [SB_DEPTH];

    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rs, rt, rd;
    logic             is_halt;
    logic             is_writer;
    logic             hazard;

    assign opcode    = Instr[31:26];
    assign rs        = Instr[25:21];
    assign rt        = Instr[20:16];
    assign rd        = Instr[15:11];
    assign is_halt   = (opcode == HALT_OP);
    assign is_writer = (opcode == OP_W'(0)) && (Instr != XLEN'(0));

    // RAW check of both source fields against every valid in-flight writer.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sbv_q[i] && (sbrd_q[i] != REG_W'(0)) &&
                ((sbrd_q[i] == rs) || (sbrd_q[i] == rt))) begin
                hazard = 1'b1;
            end
        end
    end

    // Next-state and issue decisions.
    always_comb begin
        state_d     = state_q;
        addr_d      = AddrIn;
        scnt_d      = StallCount;
        dcnt_d      = dcnt_q;
        done_d      = 1'b0;
        Issue       = 1'b0;
        Stall       = 1'b0;
        IssuedInstr = XLEN'(0);

        // Scoreboard ages every cycle; a bubble enters unless overridden below.
        sbv_d     = {sbv_q[SB_DEPTH-2:0], 1'b0};
        sbrd_d[0] = REG_W'(0);
        for (int i = 1; i < SB_DEPTH; i++) begin
            sbrd_d[i] = sbrd_q[i-1];
        end

        // Outputs stay quiet while reset is asserted; the register reset wins anyway.
        if (rst_n) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        addr_d  = PC_RESET;
                        scnt_d  = SCNT_W'(0);
                        sbv_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (is_halt) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = DCNT_W'(0);
                    end else if (hazard) begin
                        Stall = 1'b1;
                        if (StallCount != SCNT_MAX) begin
                            scnt_d = StallCount + SCNT_W'(1);
                        end
                    end else begin
                        Issue       = 1'b1;
                        IssuedInstr = Instr;
                        addr_d      = AddrIn + PC_STEP;
                        sbv_d[0]    = is_writer;
                        sbrd_d[0]   = rd;
                    end
                end
                ST_DRAIN: begin
                    if (dcnt_q == DRAIN_LAST) begin
                        state_d = ST_IDLE;
                        dcnt_d  = DCNT_W'(0);
                        done_d  = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            AddrIn     <= PC_RESET;
            StallCount <= SCNT_W'(0);
            dcnt_q     <= DCNT_W'(0);
            done       <= 1'b0;
            busy       <= 1'b0;
            sbv_q      <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sbrd_q[i] <= REG_W'(0);
            end
        end else begin
            state_q    <= state_d;
            AddrIn     <= addr_d;
            StallCount <= scnt_d;
            dcnt_q     <= dcnt_d;
            done       <= done_d;
            busy       <= busy_d;
            sbv_q      <= sbv_d;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sbrd_q[i] <= sbrd_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Testbench for pipe_issue_ctrl: random programs, random start and reset,
// checked every cycle against a behavioural pipeline model; plus a second
// instance exercising PC wrap from 32'hFFFF_FFFC.
module tb_pipe_issue_ctrl;

    localparam logic [5:0] HALT = 6'h3F;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int N_CYC   = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, w_start;
    logic [31:0] instr, addr, issued;
    logic        issue, stall, busy, done;
    logic [15:0] stall_cnt;
    logic [31:0] w_instr, w_addr, w_issued;
    logic        w_issue, w_stall, w_busy, w_done;
    logic [15:0] w_stall_cnt;

    logic [31:0] imem [256];
    logic [31:0] wmem [256];

    assign instr   = imem[addr[9:2]];
    assign w_instr = wmem[w_addr[9:2]];

    pipe_issue_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Instr(instr),
        .AddrIn(addr), .Issue(issue), .IssuedInstr(issued), .Stall(stall),
        .busy(busy), .done(done), .StallCount(stall_cnt)
    );

    pipe_issue_ctrl #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(w_start), .Instr(w_instr),
        .AddrIn(w_addr), .Issue(w_issue), .IssuedInstr(w_issued), .Stall(w_stall),
        .busy(w_busy), .done(w_done), .StallCount(w_stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    // Biased random instruction: small register set so hazards are common.
    function automatic logic [31:0] rand_instr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'h0;
        if (r == 1) return {HALT, 26'($urandom)};
        if (r == 2) return {6'($urandom_range(1, 62)), 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), 21'($urandom)};
        return {6'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    // Model: mode, PC, destination regs of the last 3 issue slots (0 = none).
    int          m_mode;
    logic [31:0] m_pc;
    logic [4:0]  m_hist [3];
    int          m_drain;
    logic        m_done;
    logic [15:0] m_stalls;
    bit          m_known;

    initial begin
        logic [31:0] ins;
        logic        halt, haz, e_issue, e_stall;
        logic [4:0]  dest;
        bit          first_done_seen;

        rst_n = 1'b0; start = 1'b0; w_start = 1'b0;
        m_known = 1'b0; first_done_seen = 1'b0;
        m_mode = M_IDLE; m_pc = 32'h0; m_drain = 0; m_done = 1'b0; m_stalls = 16'h0;
        foreach (m_hist[k]) m_hist[k] = 5'd0;

        foreach (imem[k]) imem[k] = rand_instr();
        // Opening program: writer then dependent reader then halt.
        imem[0] = rtype(1, 2, 3);
        imem[1] = {6'h00, 5'd1, 5'd5, 5'd4, 5'd0, 6'h22};
        imem[2] = {HALT, 26'h0};
        foreach (wmem[k]) wmem[k] = 32'h0;
        wmem[255] = rtype(1, 2, 3);
        wmem[0]   = rtype(4, 5, 6);
        wmem[1]   = {HALT, 26'h0};

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            if (cyc >= 1000 && cyc % 500 == 0) foreach (imem[k]) imem[k] = rand_instr();
            if (cyc < 2)        rst_n = 1'b0;
            else if (cyc < 200) rst_n = 1'b1;
            else                rst_n = ($urandom_range(0, 59) != 0);
            start = (cyc < 200) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;

            ins = imem[m_pc[9:2]];
            halt = 1'b0; haz = 1'b0; e_issue = 1'b0; e_stall = 1'b0;
            if (rst_n && m_mode == M_RUN) begin
                halt = (ins[31:26] == HALT);
                foreach (m_hist[k])
                    if (m_hist[k] != 0 && (m_hist[k] == ins[25:21] || m_hist[k] == ins[20:16]))
                        haz = 1'b1;
                e_issue = !halt && !haz;
                e_stall = !halt && haz;
            end

            if (m_known) begin
                chk("issue", 32'(issue), 32'(e_issue));
                chk("issued_instr", issued, e_issue ? ins : 32'h0);
                chk("stall", 32'(stall), 32'(e_stall));
                chk("addr", addr, m_pc);
                chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
                chk("done", 32'(done), 32'(m_done));
                chk("stall_count", 32'(stall_cnt), 32'(m_stalls));
                if (m_done && !first_done_seen) begin
                    first_done_seen = 1'b1;
                    chk("raw_stall_total", 32'(stall_cnt), 32'd3);
                end
            end

            if (!rst_n) begin
                m_mode = M_IDLE; m_pc = 32'h0; m_drain = 0; m_done = 1'b0; m_stalls = 16'h0;
                foreach (m_hist[k]) m_hist[k] = 5'd0;
            end else begin
                dest = (e_issue && ins[31:26] == 6'h00 && ins != 32'h0) ? ins[15:11] : 5'd0;
                m_hist[2] = m_hist[1];
                m_hist[1] = m_hist[0];
                m_hist[0] = dest;
                m_done = 1'b0;
                case (m_mode)
                    M_IDLE: if (start) begin
                        m_mode = M_RUN; m_pc = 32'h0; m_stalls = 16'h0;
                        foreach (m_hist[k]) m_hist[k] = 5'd0;
                    end
                    M_RUN: begin
                        if (halt) begin
                            m_mode = M_DRAIN; m_drain = 4;
                        end else if (haz) begin
                            if (m_stalls != 16'hFFFF) m_stalls = m_stalls + 16'd1;
                        end else begin
                            m_pc = m_pc + 32'd4;
                        end
                    end
                    default: begin
                        m_drain = m_drain - 1;
                        if (m_drain == 0) begin
                            m_mode = M_IDLE; m_done = 1'b1;
                        end
                    end
                endcase
            end
            m_known = 1'b1;
        end

        if (!first_done_seen) chk("first_run_done_seen", 32'd0, 32'd1);

        // Wrap instance: leave reset released, flush to IDLE, then run.
        @(negedge clk);
        start = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_reset_busy", 32'(w_busy), 32'd0);
        w_start = 1'b1;
        @(posedge clk); #1;
        w_start = 1'b0;
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        chk("wrap_issue0", 32'(w_issue), 32'd1);
        chk("wrap_instr0", w_issued, rtype(1, 2, 3));
        @(posedge clk); #1;
        chk("wrap_addr1", w_addr, 32'h0);
        chk("wrap_issue1", 32'(w_issue), 32'd1);
        @(posedge clk); #1;
        chk("wrap_halt_addr", w_addr, 32'h4);
        chk("wrap_halt_issue", 32'(w_issue), 32'd0);
        chk("wrap_halt_stall", 32'(w_stall), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk("wrap_done", 32'(w_done), 32'(k == 5));
            chk("wrap_busy", 32'(w_busy), 32'(k < 5));
        end
        chk("wrap_stall_count", 32'(w_stall_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_issue_ctrl.md
PIPE_ISSUE_CTRL -- requirements
Module: pipe_issue_ctrl

Interface
REQ-001 SHALL provide parameter PC_RESET, default 32'h0000_0000, first fetch address after start.
REQ-002 SHALL provide parameter HALT_OP, default 6'h3F, opcode that ends a program.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  in  1  level/pulse; begins a run when sampled high in IDLE.
REQ-006 SHALL have port Instr  in  32  instruction returned by instruction memory for AddrIn (same cycle).
REQ-007 SHALL have port AddrIn  out  32  registered PC driven to instruction memory and PC adder.
REQ-008 SHALL have port Issue  out  1  high: IF_ID captures IssuedInstr this edge as a real instruction.
REQ-009 SHALL have port IssuedInstr  out  32  Instr when Issue=1, else 32'h0 (NOP bubble).
REQ-010 SHALL have port Stall  out  1  high in a RUN cycle blocked by a RAW hazard.
REQ-011 SHALL have port busy  out  1  high in RUN and DRAIN.
REQ-012 SHALL have port done  out  1  one-cycle pulse, all issued instructions have written back.
REQ-013 SHALL have port StallCount  out  16  hazard-stall cycles in current/last run.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, state registered.
REQ-015 IDLE: Issue=0, IssuedInstr=0, AddrIn held; start=1 -> RUN next cycle, AddrIn<=PC_RESET, scoreboard cleared, StallCount<=0.
REQ-016 SHALL keep a 3-entry scoreboard (valid, rd[4:0]) for slots issued 1, 2, 3 cycles ago (ID, EX, MEM positions), shifted every cycle; bubble enters as valid=0.
REQ-017 Writer: entry valid=1 only when issued Instr[31:26]==6'h00 and Instr!=32'h0; rd=Instr[15:11].
REQ-018 Hazard (RUN): any valid entry with rd!=0 and rd equal to Instr[25:21] or Instr[20:16]; both fields checked for every opcode.
REQ-019 RUN, no hazard, opcode!=HALT_OP: Issue=1, AddrIn<=AddrIn+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-020 RUN, hazard: Stall=1, Issue=0, AddrIn held, StallCount+1 saturating at 16'hFFFF.
REQ-021 RUN, opcode==HALT_OP: Issue=0, Stall=0, AddrIn held, -> DRAIN; halt has priority over hazard.
REQ-022 DRAIN SHALL last exactly 4 cycles (internal 3-bit counter), Issue=0, then -> IDLE.
REQ-023 done SHALL be high only in the first IDLE cycle after DRAIN (instruction issued the cycle before halt has committed its write).
REQ-024 Issue, IssuedInstr, Stall combinational from state, Instr, scoreboard; all others registered.
REQ-025 start ignored in RUN and DRAIN; start high in the done cycle SHALL start a new run.
REQ-026 Latency: first Issue possible in cycle after start sampled; one instruction issued per unstalled RUN cycle.

Reset
REQ-027 rst_n=0 at an edge SHALL force IDLE, AddrIn=PC_RESET, scoreboard cleared, drain counter 0, done=0, StallCount=0, from any state including mid-RUN/DRAIN.
REQ-028 Outputs during/after reset: Issue=0, IssuedInstr=0, Stall=0, busy=0.

Verification
REQ-029 Independent stream: start; IM add $1,$2,$3 / add $4,$5,$6 / halt -> Issue 2 consecutive cycles, AddrIn 0,4,8, StallCount=0, done 5 cycles after halt cycle.
REQ-030 RAW: add $1,$2,$3 then sub $4,$1,$5 -> Stall high exactly 3 cycles, IssuedInstr=0 those cycles, AddrIn held at 4, StallCount=3.
REQ-031 $0 target: add $0,$2,$3 then add $4,$0,$0 -> no stall; NOP 32'h0 in stream never causes stall.
REQ-032 Halt while hazard pending: add $1,.. then halt referencing $1 fields -> DRAIN immediately, Stall=0, done after 4 DRAIN cycles.
REQ-033 Wrap: PC_RESET=32'hFFFF_FFFC, independent instr -> AddrIn 32'hFFFF_FFFC then 32'h0.
REQ-034 Reset mid-RUN with 2 valid scoreboard entries -> next cycle IDLE, AddrIn=PC_RESET, busy=0; subsequent start runs hazard-free first instruction without stall.
